// File: rtl/mips_lsu.sv
// MIPS load/store unit: aligns EX-stage memory ops onto a word-wide bus
// with byte enables, and extends returning load data for writeback.
module mips_lsu #(
    parameter int unsigned Data_Width = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic                    is_store,
    input  logic [1:0]              size,
    input  logic                    is_unsigned,
    input  logic [Data_Width-1:0]   addr,
    input  logic [Data_Width-1:0]   store_data,
    input  logic [4:0]              rd_in,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [Data_Width-1:0]   mem_addr,
    output logic [Data_Width/8-1:0] mem_be,
    output logic [Data_Width-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [Data_Width-1:0]   mem_rdata,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [Data_Width-1:0]   wb_data,
    output logic                    misalign
);

    localparam int unsigned BeW = Data_Width / 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e        state_q;
    logic          store_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [1:0]    off_q;
    logic [4:0]    rd_q;

    logic                  bad_align;
    logic [BeW-1:0]        be_d;
    logic [Data_Width-1:0] wdata_d;
    logic [Data_Width-1:0] wb_data_d;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;

    assign ex_ready = (state_q == S_IDLE);

    // Alignment check, byte enables and lane-replicated store data for the incoming op
    always_comb begin
        bad_align = 1'b0;
        be_d      = BeW'(4'b1111);
        wdata_d   = store_data;
        case (size)
            2'b00: begin
                be_d    = BeW'(4'b0001) << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                bad_align = addr[0];
                be_d      = BeW'(4'b0011) << {addr[1], 1'b0};
                wdata_d   = {2{store_data[15:0]}};
            end
            2'b10: begin
                bad_align = (addr[1:0] != 2'b00);
            end
            default: begin
                bad_align = 1'b1;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returning read word
    always_comb begin
        byte_lane = 8'(mem_rdata >> {off_q, 3'b000});
        half_lane = 16'(mem_rdata >> {off_q[1], 4'b0000});
        wb_data_d = mem_rdata;
        case (size_q)
            2'b00: wb_data_d = uns_q ? {{(Data_Width-8){1'b0}}, byte_lane}
                                     : {{(Data_Width-8){byte_lane[7]}}, byte_lane};
            2'b01: wb_data_d = uns_q ? {{(Data_Width-16){1'b0}}, half_lane}
                                     : {{(Data_Width-16){half_lane[15]}}, half_lane};
            default: wb_data_d = mem_rdata;
        endcase
    end

    // IDLE/REQ controller with registered bus, writeback and misalign outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            store_q   <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            rd_q      <= 5'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= '0;
            misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            misalign <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (bad_align) begin
                            misalign <= 1'b1;
                        end else begin
                            state_q   <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[Data_Width-1:2], 2'b00};
                            mem_be    <= be_d;
                            mem_wdata <= wdata_d;
                            store_q   <= is_store;
                            size_q    <= size;
                            uns_q     <= is_unsigned;
                            off_q     <= addr[1:0];
                            rd_q      <= rd_in;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_q <= S_IDLE;
                        mem_req <= 1'b0;
                        if (!store_q) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= wb_data_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed table, randomized ops against a
// behavioural model, and hand-written reset/back-to-back sequences.
module tb_mips_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic        is_store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;

    int n_vec = 0;
    int n_mis = 0;

    logic [31:0] exp_wb_data;
    logic [4:0]  exp_wb_rd;

    mips_lsu #(.Data_Width(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .is_store(is_store), .size(size), .is_unsigned(is_unsigned), .addr(addr),
        .store_data(store_data), .rd_in(rd_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        int unsigned dly;
        logic [31:0] rdata;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] wb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: operation size in bytes drives everything
    function automatic int unsigned nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (a % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        int unsigned off = a % 4;
        for (int k = 0; k < 4; k++)
            if (k >= off && k < off + nbytes(sz)) be[k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] w = 32'h0;
        int unsigned nb = nbytes(sz);
        for (int k = 0; k < 4; k++)
            w = w | (((sd >> (8 * (k % nb))) & 32'hFF) << (8 * k));
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a, input logic [31:0] rw);
        int unsigned nb = nbytes(sz);
        logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        logic [31:0] v = (rw >> (8 * (a % 4))) & mask;
        if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid = 1'b0; is_store = 1'b0; size = 2'b00; is_unsigned = 1'b0;
        addr = 32'h0; store_data = 32'h0; rd_in = 5'd0;
    endtask

    // Drive one operation from the negedge where the LSU is idle, check every phase
    task automatic run_op(input vec_t v);
        int guard = 0;
        while (!ex_ready && guard < 20) begin
            @(negedge clk); guard++;
        end
        chk("ready_before_accept", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; is_store = v.st; size = v.sz; is_unsigned = v.uns;
        addr = v.addr; store_data = v.sdata; rd_in = v.rd;
        mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (v.mis) begin
            chk("misalign_pulse", 32'(misalign), 32'd1);
            chk("misalign_no_req", 32'(mem_req), 32'd0);
            chk("misalign_no_wb", 32'(wb_valid), 32'd0);
            @(negedge clk);
            chk("misalign_one_cycle", 32'(misalign), 32'd0);
            chk("misalign_no_req_later", 32'(mem_req), 32'd0);
            chk("misalign_no_wb_later", 32'(wb_valid), 32'd0);
            return;
        end
        chk("no_misalign", 32'(misalign), 32'd0);
        chk("mem_req", 32'(mem_req), 32'd1);
        chk("ready_low_in_req", 32'(ex_ready), 32'd0);
        chk("mem_we", 32'(mem_we), 32'(v.st));
        chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        chk("mem_be", 32'(mem_be), 32'(v.be));
        chk("mem_wdata", mem_wdata, v.wdata);
        for (int unsigned i = 0; i < v.dly; i++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            chk("req_held", 32'(mem_req), 32'd1);
            chk("addr_held", mem_addr, {v.addr[31:2], 2'b00});
            chk("be_held", 32'(mem_be), 32'(v.be));
        end
        mem_ack = 1'b1;
        mem_rdata = v.rdata;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (!v.st) begin
            exp_wb_data = v.wb;
            exp_wb_rd = v.rd;
        end
        chk("req_dropped", 32'(mem_req), 32'd0);
        chk("ready_after_ack", 32'(ex_ready), 32'd1);
        chk("wb_valid", 32'(wb_valid), 32'(!v.st));
        chk("wb_rd", 32'(wb_rd), 32'(exp_wb_rd));
        chk("wb_data", wb_data, exp_wb_data);
        @(negedge clk);
        chk("wb_valid_one_cycle", 32'(wb_valid), 32'd0);
        chk("wb_data_hold", wb_data, exp_wb_data);
    endtask

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t r;
        idle_inputs();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        rst_n = 1'b0;

        //           st    sz     uns   addr         sdata          rd  dly rdata          mis   be       wdata          wb
        tbl[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_0000, 5'd1,  2, 32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80};
        tbl[1]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0000_0000, 5'd2,  0, 32'hBEEF_1234, 1'b0, 4'b1100, 32'h0000_0000, 32'h0000_BEEF};
        tbl[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_00A5, 5'd9,  1, 32'h0000_0000, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000};
        tbl[3]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0000_0000, 5'd5,  0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0000_0000, 5'd6,  1, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd7,  0, 32'h1234_8001, 1'b0, 4'b0011, 32'h0000_0000, 32'hFFFF_8001};
        tbl[6]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0002, 32'h0000_0000, 5'd8,  3, 32'h00AB_0000, 1'b0, 4'b0100, 32'h0000_0000, 32'h0000_00AB};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 5'd10, 0, 32'h0000_0000, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0000_0000};
        tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 5'd11, 2, 32'h0000_0000, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd12, 0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        tbl[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_0000, 5'd13, 0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        tbl[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_0000, 5'd14, 0, 32'h0000_0000, 1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        rst_n = 1'b1;
        exp_wb_data = 32'h0;
        exp_wb_rd = 5'd0;
        @(negedge clk);

        // Ack while idle must be ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_no_req", 32'(mem_req), 32'd0);
        chk("idle_ack_no_wb", 32'(wb_valid), 32'd0);

        // Directed table
        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        // Back-to-back loads with immediate acks
        ex_valid = 1'b1; size = 2'b10; addr = 32'h10; rd_in = 5'd3;
        @(posedge clk); @(negedge clk);
        idle_inputs();
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        chk("b2b_req0", 32'(mem_req), 32'd1);
        chk("b2b_addr0", mem_addr, 32'h10);
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_wbv0", 32'(wb_valid), 32'd1);
        chk("b2b_rd0", 32'(wb_rd), 32'd3);
        chk("b2b_data0", wb_data, 32'h1111_2222);
        chk("b2b_ready", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; size = 2'b10; addr = 32'h14; rd_in = 5'd4;
        @(posedge clk); @(negedge clk);
        idle_inputs();
        mem_ack = 1'b1; mem_rdata = 32'h3333_4444;
        chk("b2b_gap", 32'(wb_valid), 32'd0);
        chk("b2b_req1", 32'(mem_req), 32'd1);
        chk("b2b_addr1", mem_addr, 32'h14);
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        chk("b2b_wbv1", 32'(wb_valid), 32'd1);
        chk("b2b_rd1", 32'(wb_rd), 32'd4);
        chk("b2b_data1", wb_data, 32'h3333_4444);
        exp_wb_data = 32'h3333_4444;
        exp_wb_rd = 5'd4;
        @(negedge clk);

        // Reset while a store request is outstanding, ack arriving afterwards
        ex_valid = 1'b1; is_store = 1'b1; size = 2'b10; addr = 32'h40;
        store_data = 32'h5555_AAAA;
        @(posedge clk); @(negedge clk);
        idle_inputs();
        chk("rst_req_pending", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        chk("rst_req_dropped", 32'(mem_req), 32'd0);
        chk("rst_req_ready", 32'(ex_ready), 32'd1);
        chk("rst_req_wb_data", wb_data, 32'd0);
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_late_ack_no_wb", 32'(wb_valid), 32'd0);
        chk("rst_late_ack_no_req", 32'(mem_req), 32'd0);
        chk("rst_late_ack_idle", 32'(ex_ready), 32'd1);
        exp_wb_data = 32'h0;
        exp_wb_rd = 5'd0;

        // Randomized ops against the behavioural model
        for (int i = 0; i < 80; i++) begin
            r.st    = 1'($urandom_range(0, 1));
            r.sz    = 2'($urandom_range(0, 3));
            r.uns   = 1'($urandom_range(0, 1));
            r.addr  = $urandom;
            r.sdata = $urandom;
            r.rd    = 5'($urandom);
            r.dly   = $urandom_range(0, 3);
            r.rdata = $urandom;
            r.mis   = m_mis(r.sz, r.addr);
            r.be    = m_be(r.sz, r.addr);
            r.wdata = m_wdata(r.sz, r.sdata);
            r.wb    = m_load(r.sz, r.uns, r.addr, r.rdata);
            run_op(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
